cp0_regfile: RTL and testbench

CP0_REGFILE -- requirements
Module: cp0_regfile

---
 rtl/cp0_regfile.sv | 160 ++++++++++++++++
 tb/tb_cp0_regfile.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// CP0 system-control register file: Count/Compare timer, Status, Cause, EPC and BadVAddr,
// with MTC0 writes, MFC0 reads (write-forwarded) and exception/eret commit handling.
module cp0_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);
    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] count_q, count_d, compare_q, compare_d, status_q, status_d;
    logic [31:0] cause_q, cause_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic        toggle_q, toggle_d, timer_int_q, timer_int_d;
    logic        exc_s, wr_hit_s;

    function automatic logic [31:0] status_wr(input logic [31:0] wdata);
        return STATUS_BEV | (wdata & STATUS_WMASK);
    endfunction

    function automatic logic [31:0] cause_wr(input logic [31:0] old, input logic [31:0] wdata);
        return {old[31:10], wdata[9:8], old[7:0]};
    endfunction

    assign exc_s    = (excepttype_i != 32'd0);
    assign wr_hit_s = we_i && (waddr_i == raddr_i) && !exc_s;

    // MFC0 read mux; a same-cycle MTC0 to the read register is forwarded as it would land
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_q;
            REG_COUNT:    data_o = wr_hit_s ? data_i : count_q;
            REG_COMPARE:  data_o = wr_hit_s ? data_i : compare_q;
            REG_STATUS:   data_o = wr_hit_s ? status_wr(data_i) : status_q;
            REG_CAUSE:    data_o = wr_hit_s ? cause_wr(cause_q, data_i) : cause_q;
            REG_EPC:      data_o = wr_hit_s ? data_i : epc_q;
            default:      data_o = 32'd0;
        endcase
    end

    // Next-state: timer, exception commit (wins over MTC0), MTC0 writes, interrupt sampling
    always_comb begin
        count_d     = count_q;
        toggle_d    = ~toggle_q;
        compare_d   = compare_q;
        status_d    = status_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        badvaddr_d  = badvaddr_q;
        timer_int_d = timer_int_q;

        if (toggle_q) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            timer_int_d = 1'b1;
        end else begin
            timer_int_d = timer_int_q;
        end

        if (exc_s) begin
            case (excepttype_i)
                32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC: begin
                    cause_d[6:2] = (excepttype_i == 32'h1) ? 5'h00 : excepttype_i[4:0];
                    status_d[1]  = 1'b1;
                    // A nested exception keeps the original return point
                    if (!status_q[1]) begin
                        epc_d       = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                                        : current_inst_addr_i;
                        cause_d[31] = is_in_delayslot_i;
                    end else begin
                        epc_d = epc_q;
                    end
                    if ((excepttype_i == 32'h4) || (excepttype_i == 32'h5)) begin
                        badvaddr_d = bad_addr_i;
                    end else begin
                        badvaddr_d = badvaddr_q;
                    end
                end
                32'hE:   status_d[1] = 1'b0;
                default: status_d = status_q;
            endcase
        end else if (we_i) begin
            case (waddr_i)
                REG_COUNT: begin
                    count_d  = data_i;
                    toggle_d = 1'b0;
                end
                REG_COMPARE: begin
                    compare_d   = data_i;
                    timer_int_d = 1'b0;
                end
                REG_STATUS: status_d = status_wr(data_i);
                REG_CAUSE:  cause_d  = cause_wr(cause_q, data_i);
                REG_EPC:    epc_d    = data_i;
                default:    epc_d    = epc_q;
            endcase
        end else begin
            epc_d = epc_q;
        end

        cause_d[15:10] = {int_i[5] | timer_int_d, int_i[4:0]};
    end

    // State registers with synchronous reset overriding every same-cycle update
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 32'd0;
            toggle_q    <= 1'b0;
            compare_q   <= 32'd0;
            status_q    <= STATUS_BEV;
            cause_q     <= 32'd0;
            epc_q       <= 32'd0;
            badvaddr_q  <= 32'd0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            toggle_q    <= toggle_d;
            compare_q   <= compare_d;
            status_q    <= status_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            badvaddr_q  <= badvaddr_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = timer_int_q;
endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized traffic
// compared against an architectural model of the CP0 registers.
module tb_cp0_regfile;
    logic        clk = 1'b0;
    logic        rst, we_i, is_in_delayslot_i, timer_int_o;
    logic [4:0]  waddr_i, raddr_i;
    logic [5:0]  int_i;
    logic [31:0] data_i, excepttype_i, current_inst_addr_i, bad_addr_i, data_o;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;

    int n_vec = 0;
    int n_err = 0;

    // Architectural model: registers indexed by CP0 number, plus the half-rate phase
    logic [31:0] m_reg [0:31];
    logic        m_phase, m_timer;

    cp0_regfile dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .int_i(int_i), .excepttype_i(excepttype_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .bad_addr_i(bad_addr_i), .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
        .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_known(input logic [31:0] code);
        return code inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hE};
    endfunction

    function automatic logic [31:0] written_value(input logic [4:0] r, input logic [31:0] d);
        if (r == 5'd12) return 32'h0040_0000 | (d & 32'h0000_FF03);
        if (r == 5'd13) return (m_reg[13] & ~32'h0000_0300) | (d & 32'h0000_0300);
        if (r == 5'd8)  return m_reg[8];
        return d;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (!(r inside {5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14})) return 32'd0;
        if (we_i && waddr_i == r && excepttype_i == 32'd0) return written_value(r, data_i);
        return m_reg[r];
    endfunction

    task automatic model_clock();
        logic [31:0] nx [0:31];
        logic        nt;
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 32'd0;
            m_reg[12] = 32'h0040_0000;
            m_phase = 1'b0;
            m_timer = 1'b0;
            return;
        end
        nx = m_reg;
        nx[9] = m_reg[9] + (m_phase ? 32'd1 : 32'd0);
        nt = m_timer || (m_reg[11] != 32'd0 && m_reg[9] == m_reg[11]);
        m_phase = !m_phase;
        if (excepttype_i == 32'hE) begin
            nx[12][1] = 1'b0;
        end else if (excepttype_i != 32'd0 && is_known(excepttype_i)) begin
            nx[13][6:2] = (excepttype_i == 32'h1) ? 5'd0 : excepttype_i[4:0];
            nx[12][1] = 1'b1;
            if (!m_reg[12][1]) begin
                nx[14] = current_inst_addr_i - (is_in_delayslot_i ? 32'd4 : 32'd0);
                nx[13][31] = is_in_delayslot_i;
            end
            if (excepttype_i == 32'h4 || excepttype_i == 32'h5) nx[8] = bad_addr_i;
        end else if (excepttype_i == 32'd0 && we_i && waddr_i inside {5'd9, 5'd11, 5'd12, 5'd13, 5'd14}) begin
            nx[waddr_i] = written_value(waddr_i, data_i);
            if (waddr_i == 5'd9) m_phase = 1'b0;
            if (waddr_i == 5'd11) nt = 1'b0;
        end
        nx[13][15:10] = {int_i[5] | nt, int_i[4:0]};
        m_reg = nx;
        m_timer = nt;
    endtask

    task automatic cyc(input logic r, input logic we, input logic [4:0] wa, input logic [4:0] ra,
                       input logic [31:0] d, input logic [5:0] irq, input logic [31:0] exc,
                       input logic [31:0] pc, input logic ds, input logic [31:0] bad);
        rst = r; we_i = we; waddr_i = wa; raddr_i = ra; data_i = d; int_i = irq;
        excepttype_i = exc; current_inst_addr_i = pc; is_in_delayslot_i = ds; bad_addr_i = bad;
        #2;
        check_val("data_o", data_o, model_read(ra));
        @(posedge clk);
        model_clock();
        #1;
        check_val("count", count_o, m_reg[9]);
        check_val("compare", compare_o, m_reg[11]);
        check_val("status", status_o, m_reg[12]);
        check_val("cause", cause_o, m_reg[13]);
        check_val("epc", epc_o, m_reg[14]);
        check_val("badvaddr", badvaddr_o, m_reg[8]);
        check_val("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
    endtask

    task automatic idle(input logic r);
        cyc(r, 1'b0, 5'd0, 5'd9, 32'd0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        int guard;
        logic [31:0] codes [0:11];
        codes = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hE,
                  32'h2, 32'h7, 32'hF, 32'h100};
        foreach (m_reg[i]) m_reg[i] = 32'd0;
        m_phase = 1'b0; m_timer = 1'b0;
        rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; raddr_i = 5'd0; data_i = 32'd0; int_i = 6'd0;
        excepttype_i = 32'd0; current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
        #1;

        // Reset held two clocks
        idle(1'b1); idle(1'b1);
        check_val("rst_status", status_o, 32'h0040_0000);
        check_val("rst_others", count_o | compare_o | cause_o | epc_o | badvaddr_o, 32'd0);
        check_val("rst_timer", {31'd0, timer_int_o}, 32'd0);

        // Count/Compare timer
        cyc(1'b0, 1'b1, 5'd11, 5'd0, 32'd5, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        guard = 0;
        while (count_o != 32'd5 && guard < 40) begin idle(1'b0); guard++; end
        check_val("count_reach5", count_o, 32'd5);
        idle(1'b0);
        check_val("timer_set", {31'd0, timer_int_o}, 32'd1);
        check_val("cause15_set", {31'd0, cause_o[15]}, 32'd1);
        cyc(1'b0, 1'b1, 5'd11, 5'd0, 32'h20, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        check_val("timer_clr", {31'd0, timer_int_o}, 32'd0);

        // Syscall in a delay slot, then nested RI, then eret
        idle(1'b1);
        cyc(1'b0, 1'b0, 5'd0, 5'd14, 32'd0, 6'd0, 32'h8, 32'hBFC0_0104, 1'b1, 32'd0);
        check_val("sys_epc", epc_o, 32'hBFC0_0100);
        check_val("sys_bd", {31'd0, cause_o[31]}, 32'd1);
        check_val("sys_exccode", {27'd0, cause_o[6:2]}, 32'h8);
        check_val("sys_exl", {31'd0, status_o[1]}, 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 5'd13, 32'd0, 6'd0, 32'hA, 32'h8000_0010, 1'b0, 32'd0);
        check_val("nest_epc", epc_o, 32'hBFC0_0100);
        check_val("nest_exccode", {27'd0, cause_o[6:2]}, 32'hA);
        cyc(1'b0, 1'b0, 5'd0, 5'd12, 32'd0, 6'd0, 32'hE, 32'd0, 1'b0, 32'd0);
        check_val("eret_exl", {31'd0, status_o[1]}, 32'd0);

        // AdEL with a concurrent MTC0 to EPC
        cyc(1'b0, 1'b1, 5'd14, 5'd14, 32'hDEAD_BEEF, 6'd0, 32'h4, 32'h8000_0020, 1'b0, 32'h8000_0003);
        check_val("adel_bad", badvaddr_o, 32'h8000_0003);
        check_val("adel_epc", epc_o, 32'h8000_0020);

        // Status masking with same-cycle forwarding
        rst = 1'b0; we_i = 1'b1; waddr_i = 5'd12; raddr_i = 5'd12; data_i = 32'hFFFF_FFFF;
        excepttype_i = 32'd0;
        #2;
        check_val("fwd_status", data_o, 32'h0040_FF03);
        cyc(1'b0, 1'b1, 5'd12, 5'd12, 32'hFFFF_FFFF, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        check_val("mask_status", status_o, 32'h0040_FF03);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [4:0]  wa, ra;
            logic [31:0] d, exc;
            logic        we;
            case ($urandom_range(0, 6))
                0:       wa = 5'd9;
                1:       wa = 5'd11;
                2:       wa = 5'd12;
                3:       wa = 5'd13;
                4:       wa = 5'd14;
                5:       wa = 5'd8;
                default: wa = 5'($urandom_range(0, 31));
            endcase
            ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            d  = ($urandom_range(0, 1) == 0) ? (m_reg[9] + 32'($urandom_range(0, 6))) : $urandom;
            if (($urandom_range(0, 99) == 0)) d = 32'hFFFF_FFFF;
            we  = ($urandom_range(0, 2) != 0);
            exc = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 11)] : 32'd0;
            cyc(($urandom_range(0, 79) == 0), we, wa, ra, d, 6'($urandom),
                exc, $urandom, 1'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
